tppe_weight_scheduler: RTL

Sequences weight-pattern delivery into the TPPE front end (part_a_top weight_valid/neuron_id/col_base/weight_patterns). It walks every (neuron, column-group) pair and fetches each pattern from a weight memory over a valid/ready request and valid response interface. Each pattern is issued in lock-step with the scan-window strobe, one pair per T_WINDOW window. It also owns the TPPE enable and reports underruns where the memory did not return a pattern before the window boundary.

---
 rtl/tppe_weight_scheduler_pkg.sv | 25 ++
 rtl/tppe_weight_scheduler_pair_counter.sv | 45 ++++
 rtl/tppe_weight_scheduler.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/tppe_weight_scheduler_pkg.sv
// rtl/tppe_weight_scheduler_pkg.sv - shared state encoding and index helpers for the weight scheduler
package tppe_weight_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT_RSP,
        ST_ARMED,
        ST_ISSUE,
        ST_DRAIN
    } sched_state_e;

    function automatic int calc_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int calc_addr_w(input int num_neurons, input int num_col_groups);
        return calc_cnt_w(num_neurons * num_col_groups);
    endfunction

    function automatic int scale_col_base(input int grp, input int parallel_factor);
        return grp * parallel_factor;
    endfunction

endpackage

// File: rtl/tppe_weight_scheduler_pair_counter.sv
// rtl/tppe_weight_scheduler_pair_counter.sv - nested column-group / neuron walk with flat memory address
module tppe_weight_scheduler_pair_counter
    import tppe_weight_scheduler_pkg::*;
#(
    parameter int NUM_NEURONS    = 16,
    parameter int NEURON_ID_W    = 4,
    parameter int NUM_COL_GROUPS = 4,
    parameter int ADDR_W         = calc_addr_w(NUM_NEURONS, NUM_COL_GROUPS),
    parameter int GRP_W          = calc_cnt_w(NUM_COL_GROUPS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   advance,
    output logic [NEURON_ID_W-1:0] neuron_idx,
    output logic [GRP_W-1:0]       grp,
    output logic                   last_pair,
    output logic [ADDR_W-1:0]      addr
);

    logic grp_last;

    assign grp_last  = (grp == GRP_W'(NUM_COL_GROUPS - 1));
    assign last_pair = grp_last && (neuron_idx == NEURON_ID_W'(NUM_NEURONS - 1));
    assign addr      = ADDR_W'(neuron_idx) * ADDR_W'(NUM_COL_GROUPS) + ADDR_W'(grp);

    // Advancing past the last pair wraps both indices so a looping pass restarts at pair 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neuron_idx <= '0;
            grp        <= '0;
        end else if (clear) begin
            neuron_idx <= '0;
            grp        <= '0;
        end else if (advance) begin
            if (grp_last) begin
                grp        <= '0;
                neuron_idx <= last_pair ? '0 : neuron_idx + 1'b1;
            end else begin
                grp <= grp + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tppe_weight_scheduler.sv
// rtl/tppe_weight_scheduler.sv - fetches weight patterns and issues one (neuron, column-group) pair per scan window
module tppe_weight_scheduler
    import tppe_weight_scheduler_pkg::*;
#(
    parameter int NUM_NEURONS     = 16,
    parameter int NEURON_ID_W     = 4,
    parameter int NUM_COL_GROUPS  = 4,
    parameter int PARALLEL_FACTOR = 4,
    parameter int COL_ID_W        = 4,
    parameter int T_WINDOW        = 16,
    parameter int ADDR_W          = calc_addr_w(NUM_NEURONS, NUM_COL_GROUPS),
    parameter int UNDERRUN_W      = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                loop_en,
    input  logic                                abort,
    input  logic                                scan_start_en,
    output logic                                mem_req_valid,
    input  logic                                mem_req_ready,
    output logic [ADDR_W-1:0]                   mem_req_addr,
    input  logic                                mem_rsp_valid,
    input  logic [PARALLEL_FACTOR*T_WINDOW-1:0] mem_rsp_data,
    output logic                                tppe_enable,
    output logic                                weight_valid,
    output logic [NEURON_ID_W-1:0]              neuron_id,
    output logic [COL_ID_W-1:0]                 col_base,
    output logic [PARALLEL_FACTOR*T_WINDOW-1:0] weight_patterns,
    output logic                                busy,
    output logic                                done,
    output logic [UNDERRUN_W-1:0]               underrun_cnt
);

    localparam int GRP_W = calc_cnt_w(NUM_COL_GROUPS);

    sched_state_e           state_q, state_d;
    logic                   cnt_clear, cnt_advance, last_pair;
    logic                   capture, load_ids, strobe_missed;
    logic [NEURON_ID_W-1:0] neuron_idx;
    logic [GRP_W-1:0]       grp;

    tppe_weight_scheduler_pair_counter #(
        .NUM_NEURONS    (NUM_NEURONS),
        .NEURON_ID_W    (NEURON_ID_W),
        .NUM_COL_GROUPS (NUM_COL_GROUPS),
        .ADDR_W         (ADDR_W),
        .GRP_W          (GRP_W)
    ) u_pair_counter (
        .clk        (clk),
        .rst        (rst),
        .clear      (cnt_clear),
        .advance    (cnt_advance),
        .neuron_idx (neuron_idx),
        .grp        (grp),
        .last_pair  (last_pair),
        .addr       (mem_req_addr)
    );

    always_comb begin
        state_d       = state_q;
        cnt_clear     = 1'b0;
        cnt_advance   = 1'b0;
        mem_req_valid = 1'b0;
        weight_valid  = 1'b0;
        done          = 1'b0;
        capture       = 1'b0;
        load_ids      = 1'b0;
        strobe_missed = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    cnt_clear = 1'b1;
                    state_d   = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    mem_req_valid = 1'b1;
                    strobe_missed = scan_start_en;
                    if (mem_req_ready) state_d = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                // A response arriving with the abort is already consumed, so there is nothing to drain.
                if (abort) begin
                    state_d = mem_rsp_valid ? ST_IDLE : ST_DRAIN;
                end else begin
                    strobe_missed = scan_start_en;
                    if (mem_rsp_valid) begin
                        capture = 1'b1;
                        state_d = ST_ARMED;
                    end
                end
            end
            ST_ARMED: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (scan_start_en) begin
                    load_ids = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    weight_valid = 1'b1;
                    cnt_advance  = 1'b1;
                    if (last_pair) begin
                        done    = 1'b1;
                        state_d = loop_en ? ST_FETCH : ST_IDLE;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DRAIN: begin
                if (mem_rsp_valid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy = (state_q != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tppe_enable <= 1'b0;
        end else begin
            state_q     <= state_d;
            tppe_enable <= busy;
        end
    end

    // Pair identity is latched on entry to ISSUE so it stays stable for the strobe and holds afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            weight_patterns <= '0;
            neuron_id       <= '0;
            col_base        <= '0;
        end else begin
            if (capture) weight_patterns <= mem_rsp_data;
            if (load_ids) begin
                neuron_id <= neuron_idx;
                col_base  <= COL_ID_W'(scale_col_base(32'(grp), PARALLEL_FACTOR));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun_cnt <= '0;
        end else if (strobe_missed && (underrun_cnt != '1)) begin
            underrun_cnt <= underrun_cnt + 1'b1;
        end
    end

endmodule
